// File: rtl/vgac_param.sv
// rtl/vgac_param.sv - parametrised VGA timing generator with latency-matched pixel output pipeline
//   vga_clk     pixel clock, all state on rising edge
//   clrn        synchronous active-low reset
//   d_in        {r,g,b} pixel data returned by the frame buffer
//   row_addr    frame-buffer read row (0 during blanking)
//   col_addr    frame-buffer read column (0 during blanking)
//   rdn         active-low read strobe, low for visible positions
//   r, g, b     registered colour outputs, zero outside the visible area
//   hs, vs      registered sync outputs aligned with r/g/b
//   de          high while r/g/b carry a visible pixel
//   frame_start one-cycle pulse with pixel (0,0) on r/g/b
module vgac_param #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int COLOR_W  = 4,
   parameter int COL_W    = 10,
   parameter int ROW_W    = 9,
   parameter int RD_LAT   = 1
) (
   input  logic                   vga_clk,
   input  logic                   clrn,
   input  logic [3*COLOR_W-1:0]   d_in,
   output logic [ROW_W-1:0]       row_addr,
   output logic [COL_W-1:0]       col_addr,
   output logic                   rdn,
   output logic [COLOR_W-1:0]     r,
   output logic [COLOR_W-1:0]     g,
   output logic [COLOR_W-1:0]     b,
   output logic                   hs,
   output logic                   vs,
   output logic                   de,
   output logic                   frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Per-position flags that travel down the pipeline alongside the read.
   typedef struct packed {
      logic act;
      logic hsr;
      logic vsr;
      logic org;
   } tap_t;

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic          h_act;
   logic          v_act;
   tap_t          cur;
   tap_t          tap;

   // Reset parks the counters on the last blanking position so the first
   // released edge lands exactly on (0,0).
   always_ff @(posedge vga_clk) begin
      if (!clrn) begin
         h_cnt <= H_LAST;
         v_cnt <= V_LAST;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   assign h_act    = (h_cnt < H_ACT);
   assign v_act    = (v_cnt < V_ACT);
   assign rdn      = ~(h_act & v_act);
   assign col_addr = h_act ? COL_W'(h_cnt) : '0;
   assign row_addr = v_act ? ROW_W'(v_cnt) : '0;

   always_comb begin
      cur     = '0;
      cur.act = h_act & v_act;
      cur.hsr = (h_cnt >= H_SS) && (h_cnt <= H_SE);
      cur.vsr = (v_cnt >= V_SS) && (v_cnt <= V_SE);
      cur.org = h_act & v_act & (h_cnt == '0) & (v_cnt == '0);
   end

   // RD_LAT delay stages bring the flags level with the returning d_in;
   // the output register below is the final stage.
   generate
      if (RD_LAT == 0) begin : g_nodly
         assign tap = cur;
      end else begin : g_dly
         tap_t dly [RD_LAT];
         always_ff @(posedge vga_clk) begin
            if (!clrn) begin
               for (int i = 0; i < RD_LAT; i++) dly[i] <= '0;
            end else begin
               dly[0] <= cur;
               for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
            end
         end
         assign tap = dly[RD_LAT-1];
      end
   endgenerate

   always_ff @(posedge vga_clk) begin
      if (!clrn) begin
         r           <= '0;
         g           <= '0;
         b           <= '0;
         de          <= 1'b0;
         frame_start <= 1'b0;
         hs          <= ~HS_POL;
         vs          <= ~VS_POL;
      end else begin
         de          <= tap.act;
         frame_start <= tap.org;
         hs          <= tap.hsr ? HS_POL : ~HS_POL;
         vs          <= tap.vsr ? VS_POL : ~VS_POL;
         if (tap.act) begin
            {r, g, b} <= d_in;
         end else begin
            r <= '0;
            g <= '0;
            b <= '0;
         end
      end
   end

endmodule

// File: tb/tb_vgac_param.sv
// tb/tb_vgac_param.sv - directed bench for vgac_param at RD_LAT 1, 0 and 3 on a 14x7 raster
module tb_vgac_param;

   localparam int HA  = 8;
   localparam int HF  = 2;
   localparam int HSY = 3;
   localparam int HB  = 1;
   localparam int VA  = 4;
   localparam int VF  = 1;
   localparam int VSY = 1;
   localparam int VB  = 1;
   localparam int HT  = 14;
   localparam int VT  = 7;
   localparam int FRAME = 98;

   logic        clk = 1'b0;
   logic        clrn;
   logic [11:0] d_in   [3];
   logic [8:0]  row_a  [3];
   logic [9:0]  col_a  [3];
   logic        rdn_o  [3];
   logic [3:0]  r_o    [3];
   logic [3:0]  g_o    [3];
   logic [3:0]  b_o    [3];
   logic        hs_o   [3];
   logic        vs_o   [3];
   logic        de_o   [3];
   logic        fs_o   [3];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Instance 0: RD_LAT 1, instance 1: RD_LAT 0, instance 2: RD_LAT 3.
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         localparam int L = (gi == 0) ? 1 : (gi == 1) ? 0 : 3;
         vgac_param #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
            .HS_POL(1'b0), .VS_POL(1'b0),
            .COLOR_W(4), .COL_W(10), .ROW_W(9), .RD_LAT(L)
         ) u_dut (
            .vga_clk    (clk),
            .clrn       (clrn),
            .d_in       (d_in[gi]),
            .row_addr   (row_a[gi]),
            .col_addr   (col_a[gi]),
            .rdn        (rdn_o[gi]),
            .r          (r_o[gi]),
            .g          (g_o[gi]),
            .b          (b_o[gi]),
            .hs         (hs_o[gi]),
            .vs         (vs_o[gi]),
            .de         (de_o[gi]),
            .frame_start(fs_o[gi])
         );
      end
   endgenerate

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : (i == 1) ? 0 : 3;
   endfunction

   // Frame-buffer content: r = row+1, g = column, b = ~column.
   function automatic logic [11:0] pix(input int h, input int v);
      logic [3:0] rr, gg, bb;
      rr = 4'(v + 1);
      gg = 4'(h);
      bb = ~gg;
      return {rr, gg, bb};
   endfunction

   task automatic check(input string tag, input int i, input int e,
                        input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s lat%0d edge %0d: observed %0h expected %0h", tag, lat_of(i), e, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input int e);
      for (int i = 0; i < 3; i++) begin
         check("rst_rdn", i, e, 32'(rdn_o[i]), 32'd1);
         check("rst_row", i, e, 32'(row_a[i]), 32'd0);
         check("rst_col", i, e, 32'(col_a[i]), 32'd0);
         check("rst_rgb", i, e, 32'({r_o[i], g_o[i], b_o[i]}), 32'd0);
         check("rst_de",  i, e, 32'(de_o[i]), 32'd0);
         check("rst_hs",  i, e, 32'(hs_o[i]), 32'd1);
         check("rst_vs",  i, e, 32'(vs_o[i]), 32'd1);
         check("rst_fs",  i, e, 32'(fs_o[i]), 32'd0);
      end
   endtask

   // In cycle e each frame buffer returns the pixel addressed RD_LAT cycles
   // earlier (address cycle e' shows position e'-1); blanking returns junk.
   task automatic drive_din(input int e);
      for (int i = 0; i < 3; i++) begin
         int pos, h, v;
         pos = e - 1 - lat_of(i);
         d_in[i] = 12'hFFF;
         if (pos >= 0) begin
            h = pos % HT;
            v = (pos / HT) % VT;
            if (h < HA && v < VA) d_in[i] = pix(h, v);
         end
      end
   endtask

   // n edges after reset release; every edge checks addresses and outputs
   // against the raster position they should represent.
   task automatic run(input int n, input int exp_fs);
      int fs_cnt [3];
      int fs_e0  [3];
      int fs_last[3];
      for (int i = 0; i < 3; i++) begin
         fs_cnt[i] = 0; fs_e0[i] = -1; fs_last[i] = -1;
      end
      drive_din(0);
      for (int e = 1; e <= n; e++) begin
         tick;
         for (int i = 0; i < 3; i++) begin
            int p, h, v, q, hq, vq;
            logic a, aq;
            p = e - 1;
            h = p % HT;
            v = (p / HT) % VT;
            a = (h < HA) && (v < VA);
            check("rdn", i, e, 32'(rdn_o[i]), 32'(!a));
            check("col", i, e, 32'(col_a[i]), (h < HA) ? 32'(h) : 32'd0);
            check("row", i, e, 32'(row_a[i]), (v < VA) ? 32'(v) : 32'd0);
            q = e - 2 - lat_of(i);
            if (q < 0) begin
               check("pre_de",  i, e, 32'(de_o[i]), 32'd0);
               check("pre_rgb", i, e, 32'({r_o[i], g_o[i], b_o[i]}), 32'd0);
               check("pre_hs",  i, e, 32'(hs_o[i]), 32'd1);
               check("pre_vs",  i, e, 32'(vs_o[i]), 32'd1);
               check("pre_fs",  i, e, 32'(fs_o[i]), 32'd0);
            end else begin
               hq = q % HT;
               vq = (q / HT) % VT;
               aq = (hq < HA) && (vq < VA);
               check("de",  i, e, 32'(de_o[i]), 32'(aq));
               check("rgb", i, e, 32'({r_o[i], g_o[i], b_o[i]}), aq ? 32'(pix(hq, vq)) : 32'd0);
               check("hs",  i, e, 32'(hs_o[i]), 32'(!(hq >= HA + HF && hq <= HA + HF + HSY - 1)));
               check("vs",  i, e, 32'(vs_o[i]), 32'(!(vq == VA + VF)));
               check("fs",  i, e, 32'(fs_o[i]), 32'(aq && hq == 0 && vq == 0));
            end
            if (fs_o[i] === 1'b1) begin
               if (fs_cnt[i] == 0) fs_e0[i] = e;
               else check("fs_period", i, e, 32'(e - fs_last[i]), 32'(FRAME));
               fs_last[i] = e;
               fs_cnt[i]++;
            end
         end
         drive_din(e);
      end
      for (int i = 0; i < 3; i++) begin
         check("fs_first_edge", i, n, 32'(fs_e0[i]), 32'(2 + lat_of(i)));
         check("fs_count",      i, n, 32'(fs_cnt[i]), 32'(exp_fs));
      end
   endtask

   initial begin
      clrn = 1'b0;
      for (int i = 0; i < 3; i++) d_in[i] = 12'h000;
      repeat (3) tick;
      chk_reset(0);

      clrn = 1'b1;
      run(2 * FRAME + 6, 3);

      // Main instance is showing pixel (3,0) here; reset lands mid-pixel.
      check("de_before_rst", 0, 0, 32'(de_o[0]), 32'd1);
      clrn = 1'b0;
      tick;
      chk_reset(-1);

      clrn = 1'b1;
      run(FRAME + 12, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
